seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Downstream consumer of the BCD counter chain (seconds/minutes counters, 8 bits of packed BCD per 0–59 stage).
- Time-multiplexes DIGITS packed-BCD nibbles onto one shared 7-segment bus plus per-digit anode enables.
- Provides frame-coherent input sampling, optional leading-zero blanking, per-digit decimal point and a fixed pattern for invalid nibbles.

Parameters:
- DIGITS, 4: number of BCD nibbles/anodes, legal range 2–8.
- REFRESH_DIV, 50000: clk cycles each digit is shown, minimum 2.
- ACTIVE_LOW, 1: 1 means an, seg and dp are driven active-low (common-anode board); 0 means active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- bcd_in  in  4*DIGITS  packed BCD; nibble 0 (bits 3:0) is the least-significant digit.
- dp_in  in  DIGITS  decimal-point request per digit.
- blank_lz  in  1  when 1, blank leading zeros.
- an  out  DIGITS  digit enables, one-hot active.
- seg  out  7  segments in bit order {g,f,e,d,c,b,a}.
- dp  out  1  decimal-point segment.

Behaviour:
- One clock domain. rst is asynchronous and active-high, and all flops clear on it immediately without waiting for a clk edge.
- Reset values:
  - divider = 0, digit index idx = DIGITS-1, snapshot = 0.
  - an = all inactive, seg = all off, dp = off.
  - With ACTIVE_LOW=1 this means an = all 1, seg = 7'h7F, dp = 1.
- Divider:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted for the single cycle in which divider == REFRESH_DIV-1.
- On a tick edge:
  - idx advances: idx+1, wrapping from DIGITS-1 to 0.
  - If the new idx is 0, snapshot <= bcd_in and dp_in, and digit 0 is decoded from the live bcd_in on that same edge.
  - an, seg and dp are reloaded on that same edge for the new idx.
  - All outputs are registered, with zero added latency relative to the idx change.
- Between ticks, outputs hold. Each digit is therefore lit for exactly REFRESH_DIV cycles, and a full frame lasts DIGITS*REFRESH_DIV cycles.
- First digit after reset: digit 0 lights on edge REFRESH_DIV after reset release. Before that edge, all outputs are dark.
- Frame coherence: changes to bcd_in or dp_in mid-frame have no effect until the next wrap to idx 0. No tearing across digits within a frame.
- Decode (active-high, before polarity inversion):
  - 0 → 3F, 1 → 06, 2 → 5B, 3 → 4F, 4 → 66, 5 → 6D, 6 → 7D, 7 → 07, 8 → 7F, 9 → 6F.
  - Nibbles 10–15 → 40 (dash, segment g only).
- Leading-zero blanking:
  - Applies only when blank_lz = 1, evaluated on the snapshot.
  - A digit k ≥ 1 is blanked if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit still has its anode enabled, but seg = all off.
  - dp still follows dp_in for a blanked digit.
- Polarity: when ACTIVE_LOW = 1, an, seg and dp are the bitwise inverse of their active-high values.
- No further protocol: inputs are level-sampled and there is no handshake.

Decomposition:
- Package seg7_pkg holds:
  - the ten digit patterns and the dash pattern as 7-bit localparams;
  - SEG_OFF;
  - a function for the divider width, $clog2(REFRESH_DIV).
- One combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit active-high pattern out, dash for invalid nibbles.
- Scan, snapshot, blanking and polarity logic live in seg7_scan.

Test Plan:
(All scenarios use DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.)
- Reset release with bcd_in=16'h1234 → outputs an=F, seg=7F, dp=1 for 4 cycles; then an=1110, seg=19 (digit "4").
- Steady bcd_in=16'h1234, dp_in=0 → each step lasts 4 cycles and the frame repeats: an=1110/seg=19, then 1101/30, then 1011/24, then 0111/79.
- Mid-frame change: bcd_in switches from 1234 to 0059 while an=1101 → remaining digits of the frame still show 2 and 1. The next frame shows digit0 seg=10 (9), digit1 seg=12 (5), digit2 and digit3 seg=40 (0).
- Leading-zero blanking with blank_lz=1:
  - bcd_in=0059 → digit3 and digit2 show seg=7F with their anodes active; digits 1 and 0 show 5 and 9.
  - bcd_in=0000 → only digit0 shows seg=40.
- Invalid nibble and dp: bcd_in=00A0, dp_in=0010 → digit1 shows seg=3F (dash) with dp=0; the other digits show dp=1.
- Asynchronous reset: rst pulsed between clock edges while an=1011 → an=F, seg=7F, dp=1 immediately, before any clk edge. The scan restarts with digit 0 four cycles after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan block: active-high segment
// patterns in {g,f,e,d,c,b,a} order and the width helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Bits needed to count 0..refresh_div-1.
  function automatic int div_width(input int refresh_div);
    return $clog2(refresh_div);
  endfunction

  // Bits needed to index digits 0..digits-1.
  function automatic int idx_width(input int digits);
    return $clog2(digits);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Nibbles 10..15 are not BCD and show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map one nibble to its segment pattern.
  always_comb begin
    // NOTE: the default arm assigns seg on every path, so no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for DIGITS packed-BCD digits on one shared
// 7-segment bus. Inputs are captured once per frame (on the wrap to
// digit 0) so a frame never mixes old and new values across digits.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int              DW       = div_width(REFRESH_DIV);
  localparam int              IW       = idx_width(DIGITS);
  localparam logic [DW-1:0]   DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);
  localparam logic            POL      = (ACTIVE_LOW != 0);

  logic [DW-1:0]         divider;
  logic [IW-1:0]         idx;
  // Digit 0 is always decoded from the live inputs on the wrap edge, so
  // only the upper digits need to be held for the rest of the frame.
  logic [4*DIGITS-1:4]   snap_bcd;
  logic [DIGITS-1:1]     snap_dp;

  logic                  tick;
  logic [IW-1:0]         next_idx;
  logic [DIGITS-1:1]     lz_mask;
  logic                  zero_above;
  logic [3:0]            sel_bcd;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_next;
  logic [DIGITS-1:0]     an_next;

  assign tick     = (divider == DIV_LAST);
  assign next_idx = (idx == IDX_LAST) ? '0 : idx + IW'(1);

  // Leading-zero mask on the frame snapshot: digit k is a leading zero
  // when it and every digit above it are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (snap_bcd[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_above;
    end
  end

  // Pick the nibble, dp request and blanking for the digit about to light.
  always_comb begin
    sel_bcd   = bcd_in[3:0];
    sel_dp    = dp_in[0];
    sel_blank = 1'b0;
    for (int k = 1; k < DIGITS; k++) begin
      if (next_idx == IW'(k)) begin
        sel_bcd   = snap_bcd[4*k +: 4];
        sel_dp    = snap_dp[k];
        sel_blank = blank_lz & lz_mask[k];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

  assign seg_next = sel_blank ? SEG_OFF : dec_seg;
  assign an_next  = DIGITS'(1) << next_idx;

  // Refresh divider, digit scan, frame snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      divider  <= '0;
      idx      <= IDX_LAST;
      snap_bcd <= '0;
      snap_dp  <= '0;
      an       <= {DIGITS{POL}};
      seg      <= SEG_OFF ^ {7{POL}};
      dp       <= POL;
    end else begin
      divider <= tick ? '0 : divider + DW'(1);
      if (tick) begin
        idx <= next_idx;
        if (next_idx == '0) begin
          snap_bcd <= bcd_in[4*DIGITS-1:4];
          snap_dp  <= dp_in[DIGITS-1:1];
        end
        an  <= an_next ^ {DIGITS{POL}};
        seg <= seg_next ^ {7{POL}};
        dp  <= sel_dp ^ POL;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
// The stimulus process queues the expected output for every scan step;
// the monitor pops one entry whenever {an,seg,dp} changes and also checks
// how many cycles the previous value was held.
module tb_seg7_scan;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = 16'h1234;
  logic [3:0]  dp_in = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         check_len;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ecount = 0;
  int   step = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input bit cl);
    exp_t e;
    e.an = a;
    e.seg = s;
    e.dp = d;
    e.check_len = cl;
    exp_q.push_back(e);
  endtask

  // One full frame, digit 0 first; s* and dps are pin-level (active-low).
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dps);
    push(4'b1110, s0, dps[0], 1'b1);
    push(4'b1101, s1, dps[1], 1'b1);
    push(4'b1011, s2, dps[2], 1'b1);
    push(4'b0111, s3, dps[3], 1'b1);
  endtask

  // Posedges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  // Return 1 time unit after clock edge n (counted from reset release).
  task automatic go_to(input int n);
    while (ecount < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare each new output value against the queue head.
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    bit          have;
    int          cnt;
    exp_t        e;
    have = 1'b0;
    cnt  = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {an, seg, dp};
      if (!have || cur !== prev) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_change_at_step%0d", step), 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("step%0d_{an,seg,dp}", step), 32'(cur), 32'({e.an, e.seg, e.dp}));
          if (e.check_len)
            check($sformatf("step%0d_prev_hold_cycles", step), 32'(cnt + 1), 32'(REFRESH_DIV));
          step++;
        end
        prev = cur;
        have = 1'b1;
        cnt  = 0;
      end else if (!rst) begin
        cnt++;
      end
      if (rst) cnt = 0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Stimulus: directed input sequence with hand-computed expected steps.
  initial begin
    #2 rst = 1'b1;
    push(4'hF, 7'h7F, 1'b1, 1'b0);
    // Frames 1-3 show 1234; bcd_in changes to 0059 during frame 3 digit 1.
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
    // Frame 4 shows 0059 without blanking.
    push_frame(7'h10, 7'h12, 7'h40, 7'h40, 4'hF);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    go_to(41);
    bcd_in = 16'h0059;

    go_to(64);
    blank_lz = 1'b1;
    push_frame(7'h10, 7'h12, 7'h7F, 7'h7F, 4'hF);

    go_to(69);
    bcd_in = 16'h0000;
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);

    go_to(97);
    bcd_in   = 16'h00A0;
    dp_in    = 4'b0010;
    blank_lz = 1'b0;
    push_frame(7'h40, 7'h3F, 7'h40, 7'h40, 4'b1101);

    go_to(113);
    bcd_in   = 16'h0000;
    dp_in    = 4'b1001;
    blank_lz = 1'b1;
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0110);
    push(4'b1110, 7'h40, 1'b0, 1'b1);
    push(4'b1101, 7'h7F, 1'b1, 1'b1);
    push(4'b1011, 7'h7F, 1'b1, 1'b1);
    push(4'hF, 7'h7F, 1'b1, 1'b0);

    // Asynchronous reset between clock edges while digit 2 is lit.
    go_to(141);
    #2 rst = 1'b1;
    #1;
    check("async_reset_an", 32'(an), 32'h0000000F);
    check("async_reset_seg", 32'(seg), 32'h0000007F);
    check("async_reset_dp", 32'(dp), 32'h00000001);

    bcd_in   = 16'h1234;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    push(4'b1110, 7'h19, 1'b1, 1'b1);
    push(4'b1101, 7'h30, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    go_to(10);
    repeat (2) @(posedge clk);
    #1;
    check("expected_steps_remaining", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
